// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory geometry and loader state encoding; the
// instruction memory imports the same geometry constants.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and keeps a running
// XOR checksum of every accepted byte.
module imem_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o
);

  logic [1:0]  idx_q;
  logic [23:0] low_q;
  logic [7:0]  csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      low_q  <= '0;
      csum_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      low_q  <= '0;
      csum_q <= '0;
    end else if (byte_valid_i) begin
      idx_q  <= idx_q + 2'd1;
      csum_q <= csum_q ^ byte_i;
      case (idx_q)
        2'd0:    low_q[7:0]   <= byte_i;
        2'd1:    low_q[15:8]  <= byte_i;
        2'd2:    low_q[23:16] <= byte_i;
        default: ;
      endcase
    end
  end

  // The top byte is never stored: the full word is presented while the
  // fourth byte is still on the input, so the caller latches it that cycle.
  assign word_ready_o = byte_valid_i && (idx_q == 2'd3);
  assign word_o       = {byte_i, low_q};
  assign csum_o       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives length, little-endian words and an XOR
// checksum over a byte handshake and writes the words while stalling the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic        asm_clear;
  logic        byte_valid;
  logic        word_ready;
  logic [31:0] word;
  logic [7:0]  csum;
  logic        fire;

  assign asm_clear  = (state_q == ST_IDLE) && start;
  assign byte_valid = (state_q == ST_DATA) && rx_valid && !abort;
  assign fire       = rx_valid && rx_ready;

  imem_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst),
    .clear_i     (asm_clear),
    .byte_valid_i(byte_valid),
    .byte_i      (rx_data),
    .word_ready_o(word_ready),
    .word_o      (word),
    .csum_o      (csum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      if (word_ready) begin
        addr_q <= cnt_q[ADDR_W-1:0];
        data_q <= word;
      end
    end
  end

  always_comb begin
    rx_ready = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        rx_ready = !abort;
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (fire) begin
          if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_W) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            len_d   = rx_data[ADDR_W:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        rx_ready = !abort;
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (word_ready) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The write on this cycle always lands, even when aborted, so the
        // count must include it.
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_d == len_q) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        rx_ready = !abort;
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (fire) begin
          if (rx_data != csum) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en        = (state_q == ST_WRITE);
  assign wr_addr      = addr_q;
  assign wr_data      = data_q;
  assign busy         = (state_q != ST_IDLE);
  assign cpu_stall    = busy;
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = IMEM_ADDR_W;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          cpu_stall;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  imem_loader #(.ADDR_W(AW), .DEPTH(IMEM_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .cpu_stall   (cpu_stall),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bq_t mk_stream(input int n, input bit bad_csum);
    bq_t s;
    logic [7:0] cs = '0;
    logic [31:0] w;
    s.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        s.push_back(w[8*b +: 8]);
        cs ^= w[8*b +: 8];
      end
    end
    s.push_back(bad_csum ? ~cs : cs);
    return s;
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  // abort_p: stream index at which abort is raised (-1 for none).
  task automatic run_load(input string name, input bq_t s, input int gap, input int abort_p);
    logic [31:0] exp_data[$];
    logic [31:0] got_a[$], got_d[$];
    logic [7:0]  cs;
    int  n, nw, p, k, last_fire, last_evt;
    bit  legal, exp_err, seen_done, aborted, first;
    int  stall_bad, ready_bad, lat_bad;

    // Reference model: outcome from the stream rules alone.
    n     = int'(s[0]);
    legal = (n >= 1) && (n <= IMEM_DEPTH);
    exp_err = 1'b0;
    nw = 0;
    if (!legal) begin
      exp_err = 1'b1;
    end else begin
      cs = '0;
      for (int i = 1; i <= 4 * n; i++) cs ^= s[i];
      nw = n;
      if (abort_p >= 0) begin
        nw = (abort_p - 1) / 4;
        exp_err = 1'b1;
      end else if (s[4 * n + 1] != cs) begin
        exp_err = 1'b1;
      end
      for (int i = 0; i < nw; i++)
        exp_data.push_back({s[4*i+4], s[4*i+3], s[4*i+2], s[4*i+1]});
    end

    start = 1'b1;
    @(negedge clk);
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;

    p = 0; k = 0; last_fire = -10; last_evt = -10;
    seen_done = 0; aborted = 0; first = 1;
    stall_bad = 0; ready_bad = 0; lat_bad = 0;
    while (k < 6000) begin
      k++;
      if (!aborted && p == abort_p) begin
        abort = 1'b1;
        rx_valid = 1'b1;
      end else begin
        abort = 1'b0;
        rx_valid = (p < s.size()) && ($urandom_range(99) >= gap);
      end
      rx_data = (p < s.size()) ? s[p] : 8'h00;
      @(negedge clk);
      if (first) begin
        chk({name, "_start_clr_err"}, {31'd0, err}, 32'd0);
        chk({name, "_start_clr_wl"}, 32'(words_loaded), 32'd0);
        first = 0;
      end
      if (!cpu_stall || !busy) stall_bad++;
      if (abort) begin
        if (rx_ready) ready_bad++;
        aborted = 1;
        last_evt = k;
      end
      if (wr_en) begin
        got_a.push_back(32'(wr_addr));
        got_d.push_back(wr_data);
        if (rx_ready) ready_bad++;
        if (last_fire != k - 1) lat_bad++;
      end
      if (done) begin
        seen_done = 1;
        chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({name, "_words"}, 32'(words_loaded), 32'(nw));
        chk({name, "_done_lat"}, 32'(k - last_evt), 32'd1);
        break;
      end
      if (rx_valid && rx_ready) begin
        p++;
        last_fire = k;
        last_evt = k;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    rx_valid = 1'b0;
    if (!seen_done) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    chk({name, "_stall"}, 32'(stall_bad), 32'd0);
    chk({name, "_ready_blk"}, 32'(ready_bad), 32'd0);
    chk({name, "_wr_lat"}, 32'(lat_bad), 32'd0);
    chk({name, "_nwrites"}, 32'(got_a.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_a.size(); i++) begin
      chk({name, "_addr"}, got_a[i], 32'(i));
      chk({name, "_data"}, got_d[i], exp_data[i]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_idle_after"}, {31'd0, busy}, 32'd0);
    chk({name, "_err_sticky"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    bq_t s;
    int  wcount;

    // Power-on reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {26'd0, rx_ready, wr_en, busy, cpu_stall, done, err}, 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    s = '{8'h02, 8'h03, 8'h21, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h91};
    run_load("nominal", s, 0, -1);
    s[9] = 8'h90;
    run_load("badcsum", s, 0, -1);
    s = '{8'h00};
    run_load("len0", s, 0, -1);
    s = '{8'h41};
    run_load("len65", s, 0, -1);

    s = mk_stream(64, 1'b0);
    run_load("full64", s, 35, -1);

    for (int i = 0; i < 4; i++) begin
      s = mk_stream(int'($urandom_range(1, 9)), 1'($urandom_range(1)));
      run_load("rand", s, int'($urandom_range(0, 50)), -1);
    end

    s = mk_stream(3, 1'b0);
    run_load("abort", s, 20, 7);

    // Abort in IDLE must be ignored; err stays set from the aborted load
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;

    s = mk_stream(2, 1'b0);
    run_load("after_abort", s, 10, -1);

    // Asynchronous reset in the middle of DATA
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h02;
    @(posedge clk); #1;
    rx_data = 8'h5A;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ctrl", {26'd0, rx_ready, wr_en, busy, cpu_stall, done, err}, 32'd0);
    chk("arst_addr", 32'(wr_addr), 32'd0);
    chk("arst_data", wr_data, 32'd0);
    chk("arst_words", 32'(words_loaded), 32'd0);
    wcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en) wcount++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (wr_en || busy) wcount++;
    end
    chk("arst_quiet", 32'(wcount), 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;

    s = mk_stream(3, 1'b0);
    run_load("post_rst", s, 25, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
